div_tap_timer: RTL and testbench

//  Parametrised free-running divider with CPU-visible DIV register and NCH tap channels.

---
 rtl/div_tap_timer_pkg.sv | 34 +++
 rtl/div_tap_timer_channel.sv | 53 +++++
 rtl/div_tap_timer.sv | 115 +++++++++++
 tb/tb_div_tap_timer.sv | 243 ++++++++++++++++++++++++
 4 files changed

// File: rtl/div_tap_timer_pkg.sv
// div_tap_timer_pkg
//   Shared definitions for the divider/tap timer: register offsets, the
//   channel configuration field layout, and helpers that convert between the
//   CPU-visible config byte and the internal channel config struct.
package div_tap_timer_pkg;

  // Register map: DIV at offset 0, channel n config at CH_OFS + n
  localparam int DIV_OFS = 0;
  localparam int CH_OFS  = 1;

  // Config byte layout: {en, 2'b11, tap[4:0]}
  localparam int EN_BIT  = 7;
  localparam int TAP_LSB = 0;
  localparam int TAP_W   = 5;

  typedef struct packed {
    logic             en;
    logic [TAP_W-1:0] tap;
  } ch_cfg_t;

  // Unpack a written config byte; bits 6:5 are don't-care on write
  function automatic ch_cfg_t cfg_from_byte(input logic [7:0] b);
    ch_cfg_t c;
    c.en  = b[EN_BIT];
    c.tap = b[TAP_LSB +: TAP_W];
    return c;
  endfunction

  // Pack a channel config for readback; the unused bits read as ones
  function automatic logic [7:0] cfg_to_byte(input ch_cfg_t c);
    return {c.en, 2'b11, c.tap};
  endfunction

endpackage

// File: rtl/div_tap_timer_channel.sv
// div_tap_timer_channel
//   One tap channel: picks a divider bit (optionally shifted up by one in
//   double-speed mode) and emits a registered one-cycle pulse whenever that
//   selected bit falls, whatever the cause (count, DIV clear, disable, tap
//   change, speed toggle).
// Ports:
//   clk, reset  clock and asynchronous active-high reset
//   div         free-running divider value
//   cfg         channel enable and tap index
//   dbl_speed   double-speed mode
//   fix         shift tap by +1 in double-speed mode (fixed-rate channel)
//   pulse       registered falling-edge pulse
module div_tap_timer_channel
  import div_tap_timer_pkg::*;
#(
  parameter int DIV_W = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [DIV_W-1:0] div,
  input  ch_cfg_t          cfg,
  input  logic             dbl_speed,
  input  logic             fix,
  output logic             pulse
);

  logic [TAP_W:0] eff_tap;
  logic           tap_bit;
  logic           prev;

  // Select the tapped divider bit; taps beyond the divider read as 0
  always_comb begin
    eff_tap = {1'b0, cfg.tap} + {{TAP_W{1'b0}}, dbl_speed & fix};
    tap_bit = 1'b0;
    if (cfg.en && (int'(eff_tap) < DIV_W)) begin
      tap_bit = 1'(div >> eff_tap);
    end else begin
      tap_bit = 1'b0;
    end
  end

  // Remember last cycle's bit and register the high-to-low detection
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      prev  <= 1'b0;
      pulse <= 1'b0;
    end else begin
      prev  <= tap_bit;
      pulse <= prev & ~tap_bit;
    end
  end

endmodule

// File: rtl/div_tap_timer.sv
// div_tap_timer
//   Free-running DIV_W-bit divider with a CPU-visible upper byte and NCH tap
//   channels, each producing a one-cycle pulse on the falling edge of its
//   selected divider bit. Channel 0 also advances a STEP_W-bit step counter.
// Ports:
//   clk, reset  base clock and asynchronous active-high reset
//   sel         chip select
//   a           register address (0 = DIV, 1..NCH = channel config)
//   cpu_rd      read strobe; d is driven only while sel && cpu_rd
//   cpu_wr      write strobe; writing DIV clears it, data ignored
//   d           bidirectional CPU data bus
//   dbl_speed   double-speed mode (FIX_MASK channels keep absolute rate)
//   ch_pulse    per-channel registered falling-edge pulse
//   step        channel-0 step count
module div_tap_timer
  import div_tap_timer_pkg::*;
#(
  parameter int             DIV_W    = 16,
  parameter int             NCH      = 4,
  parameter int             STEP_W   = 3,
  parameter logic [NCH-1:0] FIX_MASK = NCH'(1'b1),
  parameter int             ADDR_W   = 4
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              sel,
  input  logic [ADDR_W-1:0] a,
  input  logic              cpu_rd,
  input  logic              cpu_wr,
  inout  wire  [7:0]        d,
  input  logic              dbl_speed,
  output logic [NCH-1:0]    ch_pulse,
  output logic [STEP_W-1:0] step
);

  logic [DIV_W-1:0] div;
  ch_cfg_t          cfg      [NCH];
  logic [7:0]       ch_bytes [NCH];
  logic [7:0]       rd_data;
  logic             div_wr;

  assign div_wr = sel && cpu_wr && (a == ADDR_W'(DIV_OFS));

  // Divider: counts every clock, cleared and held while DIV is being written
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      div <= '0;
    end else if (div_wr) begin
      div <= '0;
    end else begin
      div <= div + DIV_W'(1);
    end
  end

  // Channel config registers, written from the data bus
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int n = 0; n < NCH; n++) begin
        cfg[n] <= '0;
      end
    end else begin
      for (int n = 0; n < NCH; n++) begin
        if (sel && cpu_wr && (a == ADDR_W'(CH_OFS + n))) begin
          cfg[n] <= cfg_from_byte(d);
        end
      end
    end
  end

  for (genvar g = 0; g < NCH; g++) begin : g_ch
    assign ch_bytes[g] = cfg_to_byte(cfg[g]);

    div_tap_timer_channel #(
      .DIV_W (DIV_W)
    ) u_ch (
      .clk       (clk),
      .reset     (reset),
      .div       (div),
      .cfg       (cfg[g]),
      .dbl_speed (dbl_speed),
      .fix       (FIX_MASK[g]),
      .pulse     (ch_pulse[g])
    );
  end

  // Read mux: current register contents, so a same-cycle write is not visible yet
  always_comb begin
    rd_data = 8'hFF;
    if (a == ADDR_W'(DIV_OFS)) begin
      rd_data = div[DIV_W-1 -: 8];
    end else begin
      for (int n = 0; n < NCH; n++) begin
        if (a == ADDR_W'(CH_OFS + n)) begin
          rd_data = ch_bytes[n];
        end else begin
          rd_data = rd_data;
        end
      end
    end
  end

  assign d = (sel && cpu_rd) ? rd_data : 8'hzz;

  // Step sequencer advances the cycle after each channel-0 pulse
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      step <= '0;
    end else if (ch_pulse[0]) begin
      step <= step + STEP_W'(1);
    end else begin
      step <= step;
    end
  end

endmodule

// File: tb/tb_div_tap_timer.sv
// tb_div_tap_timer
//   Directed and randomized checks of div_tap_timer against a cycle-level
//   behavioural model: the divider is a plain integer, each channel's tapped
//   bit is extracted by shifting, and a pulse is expected one cycle after a
//   sampled bit is seen high then low.
module tb_div_tap_timer;

  localparam int             DIV_W    = 16;
  localparam int             NCH      = 4;
  localparam int             STEP_W   = 3;
  localparam logic [NCH-1:0] FIX_MASK = 4'b0001;
  localparam int             ADDR_W   = 4;
  localparam longint         DIV_MOD  = 64'd1 << DIV_W;

  logic              clk = 1'b0;
  logic              reset;
  logic              sel;
  logic [ADDR_W-1:0] a;
  logic              cpu_rd;
  logic              cpu_wr;
  logic              dbl_speed;
  logic [7:0]        d_drv;
  logic              d_oe;
  wire  [7:0]        d;
  logic [NCH-1:0]    ch_pulse;
  logic [STEP_W-1:0] step;

  int checks = 0;
  int errors = 0;

  // Behavioural model state
  longint unsigned m_div;
  bit              m_en  [NCH];
  logic [4:0]      m_tap [NCH];
  logic [NCH-1:0]  last_b;
  logic [NCH-1:0]  exp_pulse;
  int              step_cnt;

  always #5 clk = ~clk;

  assign d = d_oe ? d_drv : 8'hzz;
  // Undriven bus floats high so an idle bus is observable as 8'hFF
  for (genvar i = 0; i < 8; i++) begin : g_pu
    pullup (d[i]);
  end

  div_tap_timer #(
    .DIV_W(DIV_W), .NCH(NCH), .STEP_W(STEP_W), .FIX_MASK(FIX_MASK), .ADDR_W(ADDR_W)
  ) dut (
    .clk(clk), .reset(reset), .sel(sel), .a(a), .cpu_rd(cpu_rd), .cpu_wr(cpu_wr),
    .d(d), .dbl_speed(dbl_speed), .ch_pulse(ch_pulse), .step(step)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    checks++;
    assert (obs === expv) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, expv);
    end
  endtask

  function automatic bit m_bit(input int n);
    int eff;
    eff = int'(m_tap[n]) + ((dbl_speed && FIX_MASK[n]) ? 1 : 0);
    if (!m_en[n] || eff >= DIV_W) return 1'b0;
    return ((m_div >> eff) & 64'd1) != 0;
  endfunction

  function automatic logic [7:0] m_read(input int addr);
    if (addr == 0) return 8'((m_div >> (DIV_W - 8)) & 64'hFF);
    if (addr >= 1 && addr <= NCH) return {m_en[addr-1], 2'b11, m_tap[addr-1]};
    return 8'hFF;
  endfunction

  task automatic model_clear();
    m_div     = 0;
    last_b    = '0;
    exp_pulse = '0;
    step_cnt  = 0;
    for (int n = 0; n < NCH; n++) begin
      m_en[n]  = 1'b0;
      m_tap[n] = 5'd0;
    end
  endtask

  // One clock: sample model bits before the edge, advance, then compare
  task automatic tick();
    logic [NCH-1:0] b;
    for (int n = 0; n < NCH; n++) b[n] = m_bit(n);
    @(posedge clk);
    step_cnt  = step_cnt + int'(exp_pulse[0]);
    exp_pulse = last_b & ~b;
    last_b    = b;
    if (sel && cpu_wr && a == 4'd0) m_div = 0;
    else m_div = (m_div + 1) % DIV_MOD;
    if (sel && cpu_wr && a >= 4'd1 && int'(a) <= NCH) begin
      m_en[a-1]  = d_drv[7];
      m_tap[a-1] = d_drv[4:0];
    end
    #1;
    check("ch_pulse", 32'(ch_pulse), 32'(exp_pulse));
    check("step", 32'(step), 32'(step_cnt % (1 << STEP_W)));
    if (sel && cpu_rd) check("d_read", 32'(d), 32'(m_read(int'(a))));
    else if (!d_oe) check("d_idle", 32'(d), 32'hFF);
    @(negedge clk);
  endtask

  task automatic idle_bus();
    sel = 1'b0; cpu_rd = 1'b0; cpu_wr = 1'b0; d_oe = 1'b0; a = 4'd0;
  endtask

  task automatic wr(input logic [3:0] addr, input logic [7:0] data);
    sel = 1'b1; cpu_wr = 1'b1; cpu_rd = 1'b0; a = addr; d_drv = data; d_oe = 1'b1;
    tick();
    idle_bus();
  endtask

  task automatic rd_set(input logic [3:0] addr);
    sel = 1'b1; cpu_rd = 1'b1; cpu_wr = 1'b0; d_oe = 1'b0; a = addr;
  endtask

  task automatic do_reset();
    reset = 1'b1;
    model_clear();
    #1;
    check("rst_pulse", 32'(ch_pulse), 32'h0);
    check("rst_step", 32'(step), 32'h0);
    check("rst_d_idle", 32'(d), 32'hFF);
    @(negedge clk);
    @(negedge clk);
    reset = 1'b0;
  endtask

  task automatic run_until(input longint unsigned mask, input longint unsigned val);
    for (int i = 0; i < 400 && (m_div & mask) != val; i++) tick();
    check("reach_div", 32'(m_div & mask), 32'(val));
  endtask

  initial begin
    int first, last0, last1, seen0, seen1, ch3_cnt, r;
    reset = 1'b1; dbl_speed = 1'b0; d_drv = 8'h00;
    idle_bus();
    @(negedge clk);
    do_reset();

    // 1: ch0 tap 3, DIV cleared, first pulse 17 clocks later, step reaches 2
    wr(4'd1, 8'h83);
    wr(4'd0, 8'h00);
    first = -1;
    for (int k = 1; k <= 40; k++) begin
      tick();
      if (ch_pulse[0] && first < 0) first = k;
    end
    check("t1_first_pulse", 32'(first), 32'd17);
    check("t1_step", 32'(step), 32'd2);

    // 2: upper DIV byte rolls from 00 to 01
    run_until(64'hFFFF, 64'h00FF);
    rd_set(4'd0);
    #1;
    check("t2_div_00", 32'(d), 32'h00);
    tick();
    check("t2_div_01", 32'(d), 32'h01);
    idle_bus();

    // 3: DIV write while ch1's bit is high glitches ch1
    wr(4'd2, 8'h84);
    run_until(64'h1F, 64'h18);
    wr(4'd0, 8'h00);
    rd_set(4'd0);
    tick();
    check("t3_ch1_glitch", 32'(ch_pulse[1]), 32'd1);
    check("t3_div_zero", 32'(d), 32'h00);
    idle_bus();

    // 4: disabling ch2 glitches only if its bit was high
    wr(4'd3, 8'h82);
    run_until(64'h7, 64'h4);
    wr(4'd3, 8'h02);
    tick();
    check("t4_dis_glitch", 32'(ch_pulse[2]), 32'd1);
    wr(4'd3, 8'h82);
    run_until(64'h7, 64'h1);
    wr(4'd3, 8'h02);
    tick();
    check("t4_no_glitch_a", 32'(ch_pulse[2]), 32'd0);
    tick();
    check("t4_no_glitch_b", 32'(ch_pulse[2]), 32'd0);

    // 5: double speed: fixed ch0 period 32, unmasked ch1 period 16
    dbl_speed = 1'b1;
    wr(4'd1, 8'h83);
    wr(4'd2, 8'h83);
    for (int k = 0; k < 40; k++) tick();
    last0 = -1; last1 = -1; seen0 = 0; seen1 = 0;
    for (int k = 0; k < 128; k++) begin
      tick();
      if (ch_pulse[0]) begin
        if (last0 >= 0) check("t5_ch0_period", 32'(k - last0), 32'd32);
        last0 = k; seen0++;
      end
      if (ch_pulse[1]) begin
        if (last1 >= 0) check("t5_ch1_period", 32'(k - last1), 32'd16);
        last1 = k; seen1++;
      end
    end
    check("t5_ch0_seen", 32'(seen0 >= 3), 32'd1);
    check("t5_ch1_seen", 32'(seen1 >= 7), 32'd1);

    // 6: tap 31 never fires; randomized traffic; unmapped read; reset mid-count
    wr(4'd4, 8'h9F);
    rd_set(4'd15);
    #1;
    check("t6_unmapped", 32'(d), 32'hFF);
    idle_bus();
    ch3_cnt = 0;
    for (int k = 0; k < 1500; k++) begin
      r = int'($urandom_range(0, 99));
      if (r < 8) wr(4'($urandom_range(1, 3)), 8'($urandom));
      else if (r < 11) wr(4'd0, 8'($urandom));
      else if (r < 13) wr(4'($urandom_range(5, 15)), 8'($urandom));
      else begin
        if (r < 16) dbl_speed = ~dbl_speed;
        if (r < 60) rd_set(4'($urandom_range(0, 15)));
        else idle_bus();
        tick();
      end
      if (ch_pulse[3]) ch3_cnt++;
    end
    check("t6_tap31_silent", 32'(ch3_cnt), 32'd0);
    idle_bus();
    do_reset();
    rd_set(4'd0);
    #1;
    check("t6_rst_div", 32'(d), 32'h00);
    idle_bus();
    for (int k = 0; k < 40; k++) tick();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
